n64_vbus_tx: RTL and testbench

- Transmitter for the N64 multiplexed video bus; the counterpart of the video demux and vinfo receivers.
- Takes parallel pixels (4 sync bits plus 7-bit R, G, B) over a valid/ready handshake.
- Serialises each pixel onto VD_o[6:0]/nVDSYNC_o in the console's 4-slot pattern: sync, R, G, B.
- Used as the bus model in PPU-level benches and as the driver for the on-board self-test loopback path.

---
 rtl/n64_vbus_tx.sv | 143 ++++++++++++++
 tb/tb_n64_vbus_tx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/n64_vbus_tx.sv
// rtl/n64_vbus_tx.sv - N64 multiplexed video bus transmitter
// Buffers parallel pixels in a 2-entry FIFO and serialises them as sync/R/G/B slots.
module n64_vbus_tx #(
  parameter int color_width = 7,
  parameter int GAP_PERIOD  = 16
) (
  input  logic                         VCLK,
  input  logic                         nRST,
  input  logic                         gap_en,
  input  logic                         vdata_valid_i,
  input  logic [4+3*color_width-1:0]   vdata_i,
  output logic                         vdata_ready_o,
  output logic [color_width-1:0]       VD_o,
  output logic                         nVDSYNC_o,
  output logic                         underrun_o,
  output logic                         vsync_fall_o
);

  localparam int PW = 4 + 3*color_width;

  typedef enum logic [2:0] {
    SLOT_SYNC = 3'd0,
    SLOT_R    = 3'd1,
    SLOT_G    = 3'd2,
    SLOT_B    = 3'd3,
    SLOT_GAP  = 3'd4
  } slot_e;

  slot_e                   slot_q, slot_d;
  logic [7:0]              gap_cnt_q, gap_cnt_d;
  logic [PW-1:0]           mem_q [2];
  logic                    wr_ptr_q, rd_ptr_q;
  logic [1:0]              cnt_q, cnt_d;
  logic                    ready_q;
  logic [PW-1:0]           last_q, last_d;
  logic                    prev_vs_q, prev_vs_d;
  logic [color_width-1:0]  vd_q, vd_d;
  logic                    nvdsync_q, nvdsync_d;
  logic                    under_q, under_d;
  logic                    fall_q, fall_d;

  logic                    push, enter_sync, have_head, fifo_wr, fifo_rd;
  logic [PW-1:0]           emit_pix;

  assign vdata_ready_o = ready_q;
  assign VD_o          = vd_q;
  assign nVDSYNC_o     = nvdsync_q;
  assign underrun_o    = under_q;
  assign vsync_fall_o  = fall_q;

  always_comb begin
    slot_d    = slot_q;
    gap_cnt_d = gap_cnt_q;
    case (slot_q)
      SLOT_SYNC: slot_d = SLOT_R;
      SLOT_R:    slot_d = SLOT_G;
      SLOT_G:    slot_d = SLOT_B;
      SLOT_B: begin
        if (gap_en && gap_cnt_q == 8'(GAP_PERIOD-1)) begin
          slot_d    = SLOT_GAP;
          gap_cnt_d = '0;
        end else begin
          slot_d    = SLOT_SYNC;
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default:   slot_d = SLOT_SYNC;
    endcase
    if (!gap_en) gap_cnt_d = '0;
  end

  // An empty FIFO at the sync edge forwards a concurrent push straight to the bus.
  always_comb begin
    push       = vdata_valid_i & ready_q;
    enter_sync = (slot_d == SLOT_SYNC);
    have_head  = (cnt_q != 2'd0);
    fifo_rd    = enter_sync & have_head;
    fifo_wr    = push & ~(enter_sync & ~have_head);
    cnt_d      = cnt_q + 2'(fifo_wr) - 2'(fifo_rd);
    if (have_head)  emit_pix = mem_q[rd_ptr_q];
    else if (push)  emit_pix = vdata_i;
    else            emit_pix = last_q;
  end

  always_comb begin
    vd_d      = vd_q;
    nvdsync_d = 1'b1;
    under_d   = 1'b0;
    fall_d    = 1'b0;
    last_d    = last_q;
    prev_vs_d = prev_vs_q;
    case (slot_d)
      SLOT_SYNC: begin
        nvdsync_d = 1'b0;
        vd_d      = color_width'(emit_pix[PW-1 -: 4]);
        last_d    = emit_pix;
        under_d   = ~have_head & ~push;
        fall_d    = prev_vs_q & ~emit_pix[PW-1];
        prev_vs_d = emit_pix[PW-1];
      end
      SLOT_R:  vd_d = last_q[3*color_width-1 -: color_width];
      SLOT_G:  vd_d = last_q[2*color_width-1 -: color_width];
      SLOT_B:  vd_d = last_q[color_width-1:0];
      default: vd_d = vd_q;
    endcase
  end

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      slot_q    <= SLOT_B;
      gap_cnt_q <= '0;
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      last_q    <= {4'hF, {(PW-4){1'b0}}};
      prev_vs_q <= 1'b1;
      vd_q      <= '0;
      nvdsync_q <= 1'b1;
      under_q   <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      gap_cnt_q <= gap_cnt_d;
      if (fifo_wr) begin
        mem_q[wr_ptr_q] <= vdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (fifo_rd) rd_ptr_q <= ~rd_ptr_q;
      cnt_q     <= cnt_d;
      ready_q   <= (cnt_d < 2'd2);
      last_q    <= last_d;
      prev_vs_q <= prev_vs_d;
      vd_q      <= vd_d;
      nvdsync_q <= nvdsync_d;
      under_q   <= under_d;
      fall_q    <= fall_d;
    end
  end

endmodule

// File: tb/tb_n64_vbus_tx.sv
// tb/tb_n64_vbus_tx.sv - scoreboard bench for n64_vbus_tx
// Driver records accepted pixels in a queue; monitor checks every bus slot against it.
module tb_n64_vbus_tx;

  localparam int GP = 4;

  logic        VCLK = 1'b0;
  logic        nRST = 1'b0;
  logic        gap_en = 1'b0;
  logic        vdata_valid_i = 1'b0;
  logic [24:0] vdata_i = '0;
  logic        vdata_ready_o;
  logic [6:0]  VD_o;
  logic        nVDSYNC_o;
  logic        underrun_o;
  logic        vsync_fall_o;

  int checks = 0;
  int errors = 0;
  logic [24:0] q[$];
  bit          acc = 1'b0;
  logic [24:0] apix = '0;

  n64_vbus_tx #(.color_width(7), .GAP_PERIOD(GP)) dut (
    .VCLK(VCLK), .nRST(nRST), .gap_en(gap_en),
    .vdata_valid_i(vdata_valid_i), .vdata_i(vdata_i), .vdata_ready_o(vdata_ready_o),
    .VD_o(VD_o), .nVDSYNC_o(nVDSYNC_o), .underrun_o(underrun_o), .vsync_fall_o(vsync_fall_o)
  );

  always #5 VCLK = ~VCLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: every sync slot emits the oldest accepted pixel, or repeats the last one when none is waiting.
  initial begin
    int          exp_slot = -1;
    int          mcnt = 0;
    logic [24:0] cur = {4'hF, 21'h0};
    bit          prev_vs = 1'b1;
    logic [24:0] p;
    bit          ur;
    forever begin
      @(negedge VCLK);
      if (!nRST) begin
        chk("rst_vd", int'(VD_o), 0);
        chk("rst_nvdsync", int'(nVDSYNC_o), 1);
        chk("rst_underrun", int'(underrun_o), 0);
        chk("rst_vsync_fall", int'(vsync_fall_o), 0);
        chk("rst_ready", int'(vdata_ready_o), 0);
        exp_slot = -1;
        q.delete();
        cur = {4'hF, 21'h0};
        prev_vs = 1'b1;
        mcnt = 0;
      end else begin
        if (!gap_en) mcnt = 0;
        if (exp_slot == -1) begin
          chk("rel_nvdsync", int'(nVDSYNC_o), 1);
          chk("rel_vd", int'(VD_o), 0);
          chk("rel_ready", int'(vdata_ready_o), 0);
          exp_slot = 0;
        end else begin
          case (exp_slot)
            0: begin
              if (q.size() > 0) begin p = q.pop_front(); ur = 1'b0; end
              else begin p = cur; ur = 1'b1; end
              chk("sync_nvdsync", int'(nVDSYNC_o), 0);
              chk("sync_vd", int'(VD_o), int'({3'b000, p[24:21]}));
              chk("sync_underrun", int'(underrun_o), int'(ur));
              chk("sync_vsync_fall", int'(vsync_fall_o), int'(prev_vs && !p[24]));
              prev_vs = p[24];
              cur = p;
              exp_slot = 1;
            end
            1, 2, 3, 4: begin
              chk("data_nvdsync", int'(nVDSYNC_o), 1);
              chk("data_underrun", int'(underrun_o), 0);
              chk("data_vsync_fall", int'(vsync_fall_o), 0);
              case (exp_slot)
                1:       chk("slot_r", int'(VD_o), int'(cur[20:14]));
                2:       chk("slot_g", int'(VD_o), int'(cur[13:7]));
                default: chk(exp_slot == 3 ? "slot_b" : "slot_gap", int'(VD_o), int'(cur[6:0]));
              endcase
              if (exp_slot == 3) begin
                if (gap_en && mcnt == GP-1) begin
                  exp_slot = 4;
                  mcnt = 0;
                end else begin
                  exp_slot = 0;
                  if (gap_en) mcnt++;
                end
              end else begin
                exp_slot = (exp_slot == 4) ? 0 : exp_slot + 1;
              end
            end
            default: chk("slot_state", exp_slot, 0);
          endcase
          chk("ready", int'(vdata_ready_o), int'(q.size() < 2));
        end
      end
    end
  end

  task automatic step(input bit v, input logic [24:0] d, input bit ge);
    @(posedge VCLK); #1;
    if (acc) q.push_back(apix);
    vdata_valid_i = v;
    vdata_i       = d;
    gap_en        = ge;
    acc           = v && vdata_ready_o && nRST;
    apix          = d;
  endtask

  task automatic do_reset(input int n);
    @(posedge VCLK); #1;
    if (acc) q.push_back(apix);
    acc           = 1'b0;
    nRST          = 1'b0;
    vdata_valid_i = 1'b0;
    repeat (n) @(posedge VCLK);
    #1 nRST = 1'b1;
  endtask

  initial begin
    logic [6:0]  r = '0;
    bit          ge = 1'b0;
    bit          pat [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int          guard;
    repeat (3) @(posedge VCLK);
    #1 nRST = 1'b1;
    repeat (12) step(1'b0, '0, 1'b0);
    step(1'b1, {4'hE, 7'h11, 7'h22, 7'h33}, 1'b0);
    repeat (8) step(1'b0, '0, 1'b0);
    repeat (40) begin
      r++;
      step(1'b1, {4'($urandom), r, 14'($urandom)}, 1'b0);
    end
    repeat (80) step(1'b1, 25'($urandom), 1'b1);
    repeat (300) begin
      if ($urandom_range(0, 39) == 0) ge = ~ge;
      step($urandom_range(0, 3) != 0, 25'($urandom), ge);
    end
    repeat (10) step(1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      guard = 0;
      do begin
        step(1'b1, {pat[i], 24'($urandom)}, 1'b0);
        guard++;
      end while (!acc && guard < 10);
      chk("pat_accept", int'(acc), 1);
    end
    repeat (10) step(1'b0, '0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(5, 20)) step(1'b1, 25'($urandom), 1'($urandom));
      do_reset($urandom_range(1, 3));
      repeat ($urandom_range(3, 9)) step(1'($urandom), 25'($urandom), 1'b0);
    end
    repeat (12) step(1'b0, '0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
